// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU types: data-memory address, register word, memory ops and
// load/store-unit state, plus alignment helpers used by mem_lsu.
package mips_cpu_pkg;

  localparam int DM_AW_DEF = 13;

  typedef logic [DM_AW_DEF-1:0] dm_addr_t;
  typedef logic [31:0]          reg_t;

  localparam reg_t ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LOAD_RESP   = 2'd1,
    STORE_MERGE = 2'd2
  } lsu_state_t;

  function automatic logic is_load(input mem_op_t op);
    return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
  endfunction

  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] lo);
    case (op)
      LH, LHU, SH: return lo[0];
      LW, SW:      return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Clears the offset bits a halfword/word access cannot legally use.
  function automatic logic [1:0] force_align(input mem_op_t op, input logic [1:0] lo);
    case (op)
      LH, LHU, SH: return {lo[1], 1'b0};
      LW, SW:      return 2'b00;
      default:     return lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Combinational byte/halfword lane logic: extracts and extends a load result
// from a memory word, and merges sub-word store data into a memory word.
module lsu_lane_mux
  import mips_cpu_pkg::*;
(
  input  mem_op_t    op,
  input  logic [1:0] lo,
  input  reg_t       word,
  input  reg_t       wdata,
  output reg_t       load_data,
  output reg_t       merge_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{lo, 3'b000} +: 8];
    half_v = lo[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (op)
      LB:      load_data = {{24{byte_v[7]}}, byte_v};
      LBU:     load_data = {24'h0, byte_v};
      LH:      load_data = {{16{half_v[15]}}, half_v};
      LHU:     load_data = {16'h0, half_v};
      default: load_data = word;
    endcase

    merge_data = word;
    case (op)
      SB: merge_data[{lo, 3'b000} +: 8] = wdata[7:0];
      SH: begin
        if (lo[1]) merge_data[31:16] = wdata[15:0];
        else       merge_data[15:0]  = wdata[15:0];
      end
      default: merge_data = word;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: drives a word-wide synchronous-read data memory,
// extends sub-word loads, and does SB/SH as read-modify-write. Macro LSU_ALIGN_CHECK_EN
// enables misalignment detection; without it low address bits are forced aligned.
module mem_lsu
  import mips_cpu_pkg::*;
#(
  parameter int DM_AW = 13
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst,
  input  logic             req_valid,
  input  mem_op_t          req_op,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             stall,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             addr_err,
  output logic             dmce,
  output logic             dmwe,
  output logic [DM_AW-1:0] dmaddr,
  output logic [31:0]      dmdin,
  input  logic [31:0]      dmdout
);

  // Handshake: a request is taken in IDLE when req_valid=1; while stall=1 the
  // pipeline holds req_* stable, and the op retires in the cycle resp_valid=1.

  lsu_state_t state, state_nx;
  mem_op_t    op_q;
  logic [1:0] lo_q;
  logic [1:0] lo_eff;
  logic       misaligned;
  logic       accept;
  reg_t       load_data;
  reg_t       merge_data;

  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:DM_AW+2];

`ifdef LSU_ALIGN_CHECK_EN
  assign lo_eff     = req_addr[1:0];
  assign misaligned = is_misaligned(req_op, req_addr[1:0]);
`else
  assign lo_eff     = force_align(req_op, req_addr[1:0]);
  assign misaligned = 1'b0;
`endif

  assign accept = (state == IDLE) && req_valid && !cpu_rst;

  lsu_lane_mux u_lane_mux (
    .op         (op_q),
    .lo         (lo_q),
    .word       (dmdout),
    .wdata      (req_wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state <= IDLE;
      op_q  <= LB;
      lo_q  <= 2'b00;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q <= req_op;
        lo_q <= lo_eff;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    stall      = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = ZERO;
    addr_err   = 1'b0;
    dmce       = 1'b0;
    dmwe       = 1'b0;
    dmdin      = ZERO;

    case (state)
      IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            addr_err   = 1'b1;
            resp_valid = 1'b1;
          end else if (req_op == SW) begin
            dmce       = 1'b1;
            dmwe       = 1'b1;
            dmdin      = req_wdata;
            resp_valid = 1'b1;
          end else begin
            // Loads and sub-word stores both start with a read of the word.
            dmce     = 1'b1;
            stall    = 1'b1;
            state_nx = is_load(req_op) ? LOAD_RESP : STORE_MERGE;
          end
        end
      end
      LOAD_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = load_data;
        state_nx   = IDLE;
      end
      STORE_MERGE: begin
        dmce       = 1'b1;
        dmwe       = 1'b1;
        dmdin      = merge_data;
        resp_valid = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (cpu_rst) begin
      state_nx   = IDLE;
      stall      = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = ZERO;
      addr_err   = 1'b0;
      dmce       = 1'b0;
      dmwe       = 1'b0;
      dmdin      = ZERO;
    end
  end

  assign dmaddr = dmce ? req_addr[DM_AW+1:2] : '0;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: behavioural synchronous-read memory, scoreboard queue of
// expected {addr_err, rdata} responses, and directed plus random scenarios.
module tb_mem_lsu;
  import mips_cpu_pkg::*;

  localparam int DM_AW = 13;

  logic             cpu_clk_50M = 1'b0;
  logic             cpu_rst;
  logic             req_valid;
  mem_op_t          req_op;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic             stall;
  logic             resp_valid;
  logic [31:0]      resp_rdata;
  logic             addr_err;
  logic             dmce;
  logic             dmwe;
  logic [DM_AW-1:0] dmaddr;
  logic [31:0]      dmdin;
  logic [31:0]      dmdout;

  logic [31:0] mem [0:(1<<DM_AW)-1];
  logic [32:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  always @(posedge cpu_clk_50M) begin
    if (dmce && dmwe) mem[dmaddr] <= dmdin;
    if (dmce) dmdout <= mem[dmaddr];
  end

  mem_lsu #(.DM_AW(DM_AW)) dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst     (cpu_rst),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .addr_err    (addr_err),
    .dmce        (dmce),
    .dmwe        (dmwe),
    .dmaddr      (dmaddr),
    .dmdin       (dmdin),
    .dmdout      (dmdout)
  );

  // Drives one request, waits (bounded) for resp_valid, pops the scoreboard and
  // checks the response and the number of stall cycles. Leaves req_valid high.
  task automatic do_op(input string name, input mem_op_t op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input int exp_stall);
    int stalls;
    logic done;
    logic [32:0] want;
    @(negedge cpu_clk_50M);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    exp_q.push_back({exp_err, exp_rdata});
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      #1;
      if (stall) stalls++;
      if (resp_valid) begin
        want = exp_q.pop_front();
        checks++;
        if ({addr_err, resp_rdata} !== want)
          begin
            errors++;
            $display("FAIL %s resp: got err=%b data=%h, want err=%b data=%h",
                     name, addr_err, resp_rdata, want[32], want[31:0]);
          end
        done = 1'b1;
      end else begin
        @(negedge cpu_clk_50M);
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: no resp_valid within 8 cycles", name);
      void'(exp_q.pop_front());
    end
    checks++;
    if (stalls != exp_stall) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d, want %0d", name, stalls, exp_stall);
    end
  endtask

  task automatic go_idle();
    @(negedge cpu_clk_50M);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    cpu_rst   = 1'b1;
    req_valid = 1'b1;
    req_op    = LW;
    req_addr  = 32'h0000_0010;
    req_wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge cpu_clk_50M);
    #1;
    checks++;
    if ({stall, resp_valid, addr_err, dmce, dmwe} !== 5'b0 || resp_rdata !== 32'h0 ||
        dmaddr !== '0 || dmdin !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got stall=%b rv=%b err=%b ce=%b we=%b rd=%h a=%h din=%h, want all 0",
               stall, resp_valid, addr_err, dmce, dmwe, resp_rdata, dmaddr, dmdin);
    end
    @(negedge cpu_clk_50M);
    cpu_rst   = 1'b0;
    req_valid = 1'b0;
    #1;
    checks++;
    if ({stall, resp_valid, dmce} !== 3'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got stall=%b rv=%b ce=%b, want 0 0 0", stall, resp_valid, dmce);
    end
  endtask

  task automatic test_loads();
    mem[4] = 32'h80FF_7F01;
    do_op("lb_11",  LB,  32'h11, 32'h0, 32'h0000_007F, 1'b0, 1);
    do_op("lb_13",  LB,  32'h13, 32'h0, 32'hFFFF_FF80, 1'b0, 1);
    do_op("lbu_13", LBU, 32'h13, 32'h0, 32'h0000_0080, 1'b0, 1);
    do_op("lh_12",  LH,  32'h12, 32'h0, 32'hFFFF_80FF, 1'b0, 1);
    do_op("lhu_12", LHU, 32'h12, 32'h0, 32'h0000_80FF, 1'b0, 1);
    do_op("lh_10",  LH,  32'h10, 32'h0, 32'h0000_7F01, 1'b0, 1);
    do_op("lw_10",  LW,  32'h10, 32'h0, 32'h80FF_7F01, 1'b0, 1);
    go_idle();
  endtask

  task automatic test_sb_rmw();
    mem[4] = 32'h1122_3344;
    do_op("sb_12", SB, 32'h12, 32'h0000_00AB, 32'h0, 1'b0, 1);
    do_op("lw_after_sb", LW, 32'h10, 32'h0, 32'h11AB_3344, 1'b0, 1);
    go_idle();
    checks++;
    if (mem[4] !== 32'h11AB_3344) begin
      errors++;
      $display("FAIL sb_mem: got %h, want %h", mem[4], 32'h11AB_3344);
    end
  endtask

  task automatic test_back_to_back();
    mem[8] = 32'h0;
    do_op("sw_20", SW, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
    checks++;
    if ({dmce, dmwe} !== 2'b11 || dmdin !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL sw_port: got ce=%b we=%b din=%h, want 1 1 deadbeef", dmce, dmwe, dmdin);
    end
    do_op("sh_22", SH, 32'h22, 32'h0000_1234, 32'h0, 1'b0, 1);
    do_op("lw_20", LW, 32'h20, 32'h0, 32'h1234_BEEF, 1'b0, 1);
    go_idle();
  endtask

  task automatic test_misaligned();
    mem[1] = 32'hCAFE_F00D;
`ifdef LSU_ALIGN_CHECK_EN
    do_op("lw_06_err", LW, 32'h06, 32'h0, 32'h0, 1'b1, 0);
`else
    do_op("lw_06_forced", LW, 32'h06, 32'h0, 32'hCAFE_F00D, 1'b0, 1);
`endif
    checks++;
    if (dmce !== 1'b0) begin
      errors++;
      $display("FAIL misalign_dmce: got %b, want 0", dmce);
    end
    go_idle();
  endtask

  task automatic test_reset_in_merge();
    mem[12] = 32'h5566_7788;
    @(negedge cpu_clk_50M);
    req_valid = 1'b1;
    req_op    = SH;
    req_addr  = 32'h30;
    req_wdata = 32'h0000_9999;
    #1;
    checks++;
    if ({stall, dmce, dmwe} !== 3'b110) begin
      errors++;
      $display("FAIL sh_issue: got stall=%b ce=%b we=%b, want 1 1 0", stall, dmce, dmwe);
    end
    @(negedge cpu_clk_50M);
    cpu_rst = 1'b1;
    #1;
    checks++;
    if ({stall, resp_valid, addr_err, dmce, dmwe} !== 5'b0 || dmdin !== 32'h0 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL merge_reset_outputs: got stall=%b rv=%b err=%b ce=%b we=%b din=%h, want all 0",
               stall, resp_valid, addr_err, dmce, dmwe, dmdin);
    end
    @(negedge cpu_clk_50M);
    cpu_rst   = 1'b0;
    req_valid = 1'b0;
    #1;
    checks++;
    if ({stall, resp_valid, dmce} !== 3'b0 || mem[12] !== 32'h5566_7788) begin
      errors++;
      $display("FAIL merge_reset_after: got stall=%b rv=%b ce=%b mem=%h, want 0 0 0 55667788",
               stall, resp_valid, dmce, mem[12]);
    end
    do_op("lw_30_after_reset", LW, 32'h30, 32'h0, 32'h5566_7788, 1'b0, 1);
    go_idle();
  endtask

  task automatic test_wrap();
    mem[0] = 32'h0;
    do_op("sw_8000", SW, 32'h0000_8000, 32'h0BAD_C0DE, 32'h0, 1'b0, 0);
    checks++;
    if (dmaddr !== '0) begin
      errors++;
      $display("FAIL wrap_dmaddr: got %h, want 0", dmaddr);
    end
    do_op("lw_0", LW, 32'h0, 32'h0, 32'h0BAD_C0DE, 1'b0, 1);
    go_idle();
  endtask

  task automatic test_random_sb();
    for (int i = 0; i < 6; i++) begin
      int unsigned idx;
      logic [31:0] base, merged;
      logic [7:0]  b;
      logic [1:0]  lane;
      idx  = $urandom_range(32, 63);
      base = $urandom;
      b    = 8'($urandom_range(0, 255));
      lane = 2'($urandom_range(0, 3));
      mem[idx] = base;
      merged = base;
      case (lane)
        2'd0: merged[7:0]   = b;
        2'd1: merged[15:8]  = b;
        2'd2: merged[23:16] = b;
        default: merged[31:24] = b;
      endcase
      do_op("rnd_sb", SB, {idx[29:0], lane}, {24'hFFFFFF, b}, 32'h0, 1'b0, 1);
      do_op("rnd_lbu", LBU, {idx[29:0], lane}, 32'h0, {24'h0, b}, 1'b0, 1);
      do_op("rnd_lw", LW, {idx[29:0], 2'b00}, 32'h0, merged, 1'b0, 1);
    end
    go_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loads();
    test_sb_rmw();
    test_back_to_back();
    test_misaligned();
    test_reset_in_merge();
    test_wrap();
    test_random_sb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-stage load/store unit for the MIPS pipeline. It takes one memory operation per request from the EX/MEM register and drives the word-wide, synchronous-read data memory port (`dmce`/`dmwe`/`dmaddr`/`dmdin`/`dmdout`). It sign- or zero-extends sub-word loads. Because the data memory has no byte enables, it performs SB/SH as a two-cycle read-modify-write, and it stalls the pipeline whenever an operation needs more than one cycle.

## Interface
- `DM_AW`, default 13: data-memory word-address width; must equal `$bits(dm_addr_t)`.
- `cpu_clk_50M`  in  1: CPU clock; all state changes on the rising edge.
- `cpu_rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: a memory operation is present. It must be held stable while `stall`=1.
- `req_op`  in  `mem_op_t` (3): LB, LBU, LH, LHU, LW, SB, SH, SW.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data; the sub-word value is in the low bits.
- `stall`  out  1: hold the pipeline; the current request is not retired this cycle.
- `resp_valid`  out  1: one-cycle pulse; the operation retires this cycle.
- `resp_rdata`  out  32: extended load result when `resp_valid` is high on a load; 0 otherwise.
- `addr_err`  out  1: one-cycle pulse, coincident with `resp_valid`, for a misaligned access.
- `dmce`  out  1: data-memory chip enable.
- `dmwe`  out  1: data-memory write enable.
- `dmaddr`  out  `DM_AW`: word address, equal to `req_addr[DM_AW+1:2]`.
- `dmdin`  out  32: write data.
- `dmdout`  in  32: read data, valid one cycle after a read is issued.

## Operation
- FSM states: IDLE, LOAD_RESP, STORE_MERGE.
- Memory-port outputs are combinational from the state and the request, so a read issues in the acceptance cycle.
- IDLE, `req_valid`=0: `dmce`=0, `stall`=0, `resp_valid`=0.
- IDLE, load accepted:
  - Issues `dmce`=1, `dmwe`=0 and `stall`=1.
  - Latches op and `addr[1:0]`, then moves to LOAD_RESP.
- LOAD_RESP:
  - Selects the lane from `dmdout` and extends it: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - `resp_valid`=1, `stall`=0, `dmce`=0; returns to IDLE.
  - The still-present request is not re-issued. The next request is taken in the following cycle.
- IDLE, SW accepted: `dmce`=1, `dmwe`=1, `dmdin`=`req_wdata`, `resp_valid`=1, `stall`=0. Stays in IDLE.
- IDLE, SB/SH accepted: issues a read of the target word with `stall`=1 and moves to STORE_MERGE.
- STORE_MERGE:
  - `dmdin` = `dmdout` with the addressed byte (SB) or halfword (SH) replaced from `req_wdata[7:0]` or `req_wdata[15:0]`.
  - `dmce`=1, `dmwe`=1, `resp_valid`=1, `stall`=0; returns to IDLE.
- Byte lanes are little-endian: `addr[1:0]`=0 selects bits 7:0, and 3 selects bits 31:24. A halfword at `addr[1]`=1 is bits 31:16.
- Misalignment is LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0.
  - Handled in IDLE: `addr_err`=1, `resp_valid`=1, `resp_rdata`=0, `dmce`=0, `stall`=0.
  - The state stays IDLE and memory is untouched.
- Bits of `req_addr` above `DM_AW+1` are ignored, so addresses wrap modulo the memory size.

## Timing
- Reset: while `cpu_rst`=1 all outputs are 0, including `dmce`/`dmwe`. After the edge the state is IDLE.
- Reset in STORE_MERGE drops the pending write, so memory is unchanged.
- Reset in LOAD_RESP drops the response.
- Latency from acceptance to `resp_valid`:
  - Loads: 1 cycle; `stall` is high for 1 cycle.
  - SW: 0 cycles.
  - SB/SH: 1 cycle; `stall` is high for 1 cycle, and the write occurs in the retire cycle.
  - Misaligned access: 0 cycles.
- Back-to-back operations: a new request can be accepted in the cycle after any retire. Throughput is 1 op per cycle for SW and 1 op per 2 cycles for the other ops.
- A store followed by a load to the same word is safe: the write lands in the store's retire cycle, before the load's read issues.

## Configuration
- Macro `LSU_ALIGN_CHECK_EN`.
- Defined: misalignment detection and `addr_err` behave as described above.
- Undefined:
  - `addr_err` is tied to 0.
  - Low address bits are forced aligned (bit 0 for halfword ops, bits 1:0 for word ops), and the operation proceeds normally.

## Structure
- `mips_cpu_pkg` gains:
  - `mem_op_t` (3-bit enum).
  - `lsu_state_t` (IDLE, LOAD_RESP, STORE_MERGE).
  - The existing `dm_addr_t`, `reg_t` and `ZERO` are reused.
- One sub-module, `lsu_lane_mux`: purely combinational lane extract/extend and merge, driven by op, `addr[1:0]`, word data and store data.

## Test plan
- Preload word 4 with 0x80FF_7F01.
  - LB at 0x11 gives 0x0000_007F. LB at 0x13 gives 0xFFFF_FF80.
  - LBU at 0x13 gives 0x0000_0080. LH at 0x12 gives 0xFFFF_80FF.
  - Each has `stall` high for 1 cycle and `resp_valid` on the next cycle.
- SB 0xAB to 0x12 over word 0x1122_3344 → memory 0x11AB_3344. `stall` high for 1 cycle; a following LW returns 0x11AB_3344.
- SW 0xDEAD_BEEF to 0x20 → `resp_valid` in the same cycle with `stall`=0. An immediately following SH 0x1234 to 0x22 → 0x1234_BEEF.
- With `LSU_ALIGN_CHECK_EN` defined, LW at 0x06 → `addr_err`=`resp_valid`=1, `dmce`=0, `resp_rdata`=0. Without the macro, the same access reads word 1.
- Assert `cpu_rst` in the STORE_MERGE cycle of an SH → no write (word unchanged), all outputs 0, IDLE afterwards.
- Address 0x0000_8000 with `DM_AW`=13 → wraps to word 0.
